// File: rtl/dwc_pcie_axi_rr_arb.sv
// dwc_pcie_axi_rr_arb
// Burst-locked round-robin arbiter sharing one AXI channel (vld/chanl/rdy)
// between P_NUM_SRC requesters. Arbitration takes one IDLE cycle. The winner
// then owns the channel until its beat flagged last completes the handshake.
module dwc_pcie_axi_rr_arb #(
  parameter  int P_NUM_SRC = 4,
  parameter  int CHAN_WD   = 3,
  parameter  int TP        = 0,
  localparam int GW        = (P_NUM_SRC > 1) ? $clog2(P_NUM_SRC) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clrn,
  input  logic [P_NUM_SRC-1:0]           vld_from_src,
  input  logic [P_NUM_SRC*CHAN_WD-1:0]   chanl_from_src,
  input  logic [P_NUM_SRC-1:0]           last_from_src,
  output logic [P_NUM_SRC-1:0]           rdy_to_src,
  output logic                           vld_to_dest,
  output logic [CHAN_WD-1:0]             chanl_to_dest,
  input  logic                           rdy_from_dest,
  output logic [GW-1:0]                  grant_id,
  output logic                           busy
);

  // TP is a simulation delay parameter. This RTL is zero-delay, so the value
  // is accepted for instantiation compatibility and has no effect.
  if (TP < 0) begin : g_tp_neg
  end

  typedef enum logic {S_IDLE = 1'b0, S_LOCK = 1'b1} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [GW-1:0]        r_ptr;
  logic [GW-1:0]        w_ptr_nxt;
  logic [GW-1:0]        r_grant;
  logic [GW-1:0]        w_grant_nxt;

  logic [GW-1:0]        w_win;
  logic                 w_any;
  logic                 w_g_vld;
  logic                 w_g_last;
  logic [CHAN_WD-1:0]   w_g_chanl;
  logic [P_NUM_SRC-1:0] w_g_oh;
  logic                 w_beat;

  // Round-robin search: first requesting source at or above ptr, wrapping at P_NUM_SRC
  always_comb begin
    int   idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    w_win = '0;
    w_any = |vld_from_src;
    for (int k = 0; k < P_NUM_SRC; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= P_NUM_SRC) idx = idx - P_NUM_SRC;
      if (!found && vld_from_src[idx]) begin
        found = 1'b1;
        w_win = GW'(idx);
      end
    end
  end

  // Mux out the granted source's signals; compare-based so any P_NUM_SRC works
  always_comb begin
    w_g_vld   = 1'b0;
    w_g_last  = 1'b0;
    w_g_chanl = '0;
    w_g_oh    = '0;
    for (int i = 0; i < P_NUM_SRC; i++) begin
      if (r_grant == GW'(i)) begin
        w_g_vld   = vld_from_src[i];
        w_g_last  = last_from_src[i];
        w_g_chanl = chanl_from_src[i*CHAN_WD +: CHAN_WD];
        w_g_oh[i] = 1'b1;
      end
    end
  end

  assign w_beat = w_g_vld & rdy_from_dest;

  // State, pointer and grant registers; clrn behaves like a synchronous rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
    end else if (!clrn) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_grant <= w_grant_nxt;
    end
  end

  // Next state: latch the winner in IDLE, release on the last beat handshake
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_grant_nxt = r_grant;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_LOCK;
          w_grant_nxt = w_win;
        end
      end
      S_LOCK: begin
        if (w_beat && w_g_last) begin
          w_state_nxt = S_IDLE;
          // Explicit wrap so non-power-of-two source counts stay in range
          w_ptr_nxt   = (r_grant == GW'(P_NUM_SRC - 1)) ? '0 : r_grant + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs: channel routed from the granted source only while locked
  always_comb begin
    vld_to_dest   = 1'b0;
    chanl_to_dest = '0;
    rdy_to_src    = '0;
    busy          = 1'b0;
    if (r_state == S_LOCK) begin
      vld_to_dest   = w_g_vld;
      chanl_to_dest = w_g_chanl;
      rdy_to_src    = w_g_oh & {P_NUM_SRC{rdy_from_dest}};
      busy          = 1'b1;
    end
  end

  assign grant_id = r_grant;

endmodule

// File: tb/tb_dwc_pcie_axi_rr_arb.sv
// Bench for dwc_pcie_axi_rr_arb: a 4-source and a 3-source instance share
// stimulus and are compared every cycle against a transaction-level model
// (owner of the channel, preferred next source, last granted source).
module tb_dwc_pcie_axi_rr_arb;

  logic        clk = 1'b0;
  logic        rst, clrn, rdy_d;
  logic [3:0]  vld, last;
  logic [11:0] ch;

  logic [3:0]  r4;  logic v4;  logic [2:0] c4;  logic [1:0] g4;  logic b4;
  logic [2:0]  r3;  logic v3;  logic [2:0] c3;  logic [1:0] g3;  logic b3;

  always #5 clk = ~clk;

  dwc_pcie_axi_rr_arb #(.P_NUM_SRC(4), .CHAN_WD(3), .TP(0)) u_dut4 (
    .clk(clk), .rst(rst), .clrn(clrn),
    .vld_from_src(vld), .chanl_from_src(ch), .last_from_src(last),
    .rdy_to_src(r4), .vld_to_dest(v4), .chanl_to_dest(c4),
    .rdy_from_dest(rdy_d), .grant_id(g4), .busy(b4)
  );

  dwc_pcie_axi_rr_arb #(.P_NUM_SRC(3), .CHAN_WD(3), .TP(0)) u_dut3 (
    .clk(clk), .rst(rst), .clrn(clrn),
    .vld_from_src(vld[2:0]), .chanl_from_src(ch[8:0]), .last_from_src(last[2:0]),
    .rdy_to_src(r3), .vld_to_dest(v3), .chanl_to_dest(c3),
    .rdy_from_dest(rdy_d), .grant_id(g3), .busy(b3)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state per instance (0: 4 sources, 1: 3 sources)
  int own [2];   // current channel owner, -1 when free
  int pref[2];   // source searched first at the next arbitration
  int mg  [2];   // most recently granted source
  logic rec = 1'b0;
  int gq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
  endtask

  function automatic int ns(input int m);
    return (m == 0) ? 4 : 3;
  endfunction

  task automatic check_inst(input int m);
    logic [3:0] ar, er;
    logic       av, ab, ev, eb;
    logic [2:0] ac, ec;
    logic [1:0] ag;
    string      p;
    p = $sformatf("n%0d", ns(m));
    if (m == 0) begin ar = r4; av = v4; ac = c4; ag = g4; ab = b4; end
    else        begin ar = {1'b0, r3}; av = v3; ac = c3; ag = g3; ab = b3; end
    eb = (own[m] >= 0);
    ev = 1'b0; ec = '0; er = '0;
    if (eb) begin
      ev = vld[own[m]];
      ec = ch[own[m]*3 +: 3];
      if (rdy_d) er = 4'b0001 << own[m];
    end
    chk({p, ".busy"},  32'(ab), 32'(eb));
    chk({p, ".vld"},   32'(av), 32'(ev));
    chk({p, ".chanl"}, 32'(ac), 32'(ec));
    chk({p, ".rdy"},   32'(ar), 32'(er));
    chk({p, ".gid"},   32'(ag), 32'(mg[m]));
  endtask

  // One clock: drive at negedge, check, predict, then commit after posedge
  task automatic step(input logic [3:0] v, input logic [3:0] l, input logic [11:0] c,
                      input logic r, input logic cl, input logic rs);
    int no[2], np[2], nm[2];
    @(negedge clk);
    vld = v; last = l; ch = c; rdy_d = r; clrn = cl; rst = rs;
    if (rs) for (int m = 0; m < 2; m++) begin own[m] = -1; pref[m] = 0; mg[m] = 0; end
    #1;
    for (int m = 0; m < 2; m++) check_inst(m);
    if (rec && b4 && v4 && rdy_d) gq.push_back(int'(g4));
    for (int m = 0; m < 2; m++) begin
      no[m] = own[m]; np[m] = pref[m]; nm[m] = mg[m];
      if (rs || !cl) begin
        no[m] = -1; np[m] = 0; nm[m] = 0;
      end else if (own[m] < 0) begin
        for (int k = 0; k < ns(m); k++) begin
          int s;
          s = (pref[m] + k) % ns(m);
          if (no[m] < 0 && v[s]) begin no[m] = s; nm[m] = s; end
        end
      end else if (v[own[m]] && r && l[own[m]]) begin
        np[m] = (own[m] + 1) % ns(m);
        no[m] = -1;
      end
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin own[m] = no[m]; pref[m] = np[m]; mg[m] = nm[m]; end
  endtask

  initial begin
    int bc, po;
    logic [3:0] lv, vv;
    rst = 1'b1; clrn = 1'b1; rdy_d = 1'b0; vld = '0; last = '0; ch = '0;
    for (int m = 0; m < 2; m++) begin own[m] = -1; pref[m] = 0; mg[m] = 0; end

    // reset held with every source requesting, then rotation with single beats
    repeat (3) step(4'hF, 4'hF, 12'o7531, 1'b1, 1'b1, 1'b1);
    rec = 1'b1;
    repeat (12) step(4'hF, 4'hF, 12'o7531, 1'b1, 1'b1, 1'b0);
    rec = 1'b0;
    chk("rot.count", 32'(gq.size() >= 5), 32'd1);
    for (int i = 0; i < 5 && i < gq.size(); i++) chk($sformatf("rot.g%0d", i), 32'(gq[i]), 32'(i % 4));

    // src1 4-beat burst while src0 and src2 keep requesting
    bc = 0;
    for (int i = 0; i < 16; i++) begin
      lv = 4'b1101 | ((bc == 3) ? 4'b0010 : 4'b0000);
      vv = (bc >= 4) ? 4'b0101 : 4'b0111;
      po = own[0];
      step(vv, lv, {3'd6, 3'd5, 3'(bc + 1), 3'd4}, 1'b1, 1'b1, 1'b0);
      if (po == 1) bc++;
    end
    chk("burst.beats", 32'(bc), 32'd4);

    // backpressure on a last beat
    repeat (2) step(4'b0001, 4'b0001, 12'o0003, 1'b0, 1'b1, 1'b0);
    repeat (5) step(4'b0001, 4'b0001, 12'o0003, 1'b0, 1'b1, 1'b0);
    repeat (2) step(4'b0001, 4'b0001, 12'o0003, 1'b1, 1'b1, 1'b0);

    // wrap (ptr=2 on the 3-source instance) and a vld gap mid-burst
    repeat (2) step(4'b0010, 4'b0010, 12'o0020, 1'b1, 1'b1, 1'b0);
    repeat (2) step(4'b0001, 4'b0000, 12'o0001, 1'b1, 1'b1, 1'b0);
    repeat (3) step(4'b0010, 4'b0000, 12'o0020, 1'b1, 1'b1, 1'b0);
    repeat (2) step(4'b0001, 4'b0001, 12'o0002, 1'b1, 1'b1, 1'b0);

    // synchronous clear in the middle of a 4-beat burst, then re-arbitration
    repeat (2) step(4'b0100, 4'b0000, 12'o0300, 1'b1, 1'b1, 1'b0);
    step(4'b0100, 4'b0000, 12'o0400, 1'b1, 1'b0, 1'b0);
    repeat (4) step(4'hF, 4'hF, 12'o1234, 1'b1, 1'b1, 1'b0);

    // randomized traffic with occasional clear and asynchronous reset
    for (int i = 0; i < 3000; i++) begin
      step(4'($urandom), 4'($urandom), 12'($urandom),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) != 0),
           ($urandom_range(0, 199) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
